pipeline_hazard_controller: RTL and testbench

Central stall/flush sequencer for the RV32E in-order pipeline (IF, ID, EX, MEMPREP, MEM, WB).
- Detects load-use hazards between ID and the EX/MEMPREP stages and inserts bubbles.
- Freezes the pipeline while the LSU waits for memory.
- Flushes IF/ID on a taken branch.
Drives the stall/flush/invalid controls of every pipeline register.

---
 rtl/pipeline_hazard_controller.sv | 202 ++++++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipeline_hazard_controller: stall/flush sequencer for the RV32E pipeline  |
// | Optional HAZARD_PERF_EN adds stall-cycle and flush-pulse counters.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pipeline_hazard_controller #(
  parameter int LOAD_USE_BUBBLES = 2,
  parameter int MEM_TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  rs1_ID,
  input  logic [3:0]  rs2_ID,
  input  logic        rs1_used_ID,
  input  logic        rs2_used_ID,
  input  logic [3:0]  rd_EX,
  input  logic        regfile_we_EX,
  input  logic [1:0]  rd_data_sel_EX,
  input  logic        invalid_EX,
  input  logic [3:0]  rd_MEMPREP,
  input  logic        regfile_we_MEMPREP,
  input  logic [1:0]  rd_data_sel_MEMPREP,
  input  logic        branch_taken_EX,
  input  logic        lsu_req_MEM,
  input  logic        lsu_ack,
  output logic        stall_IF,
  output logic        stall_ID,
  output logic        bubble_EX,
  output logic        flush_IF,
  output logic        flush_ID,
  output logic        stall_MEM,
  output logic [1:0]  ctrl_state,
  output logic        mem_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_count
`endif
);

  localparam logic [1:0] c_st_run      = 2'd0;
  localparam logic [1:0] c_st_load_use = 2'd1;
  localparam logic [1:0] c_st_mem_wait = 2'd2;

  localparam logic [1:0] c_bub_ex  = 2'(LOAD_USE_BUBBLES - 1);
  localparam logic [1:0] c_bub_mp  = 2'(LOAD_USE_BUBBLES - 2);
  localparam logic       c_mp_en   = (LOAD_USE_BUBBLES >= 2);
  localparam logic [7:0] c_timeout = 8'(MEM_TIMEOUT);

  logic [1:0] r_state, w_state_nxt;
  logic [1:0] r_bub_cnt, w_bub_nxt;
  logic [7:0] r_wait_cnt, w_wait_nxt;
  logic       r_mem_timeout, w_tmo_nxt;

  logic w_rs1_hit_ex, w_rs2_hit_ex, w_rs1_hit_mp, w_rs2_hit_mp;
  logic w_load_ex, w_load_mp, w_hz_ex, w_hz_mp;
  logic w_lsu_wait, w_branch;

  // Register x0 never carries a dependency, so it is excluded from matching.
  assign w_rs1_hit_ex = rs1_used_ID && (rs1_ID != 4'd0) && (rs1_ID == rd_EX);
  assign w_rs2_hit_ex = rs2_used_ID && (rs2_ID != 4'd0) && (rs2_ID == rd_EX);
  assign w_rs1_hit_mp = rs1_used_ID && (rs1_ID != 4'd0) && (rs1_ID == rd_MEMPREP);
  assign w_rs2_hit_mp = rs2_used_ID && (rs2_ID != 4'd0) && (rs2_ID == rd_MEMPREP);

  assign w_load_ex  = regfile_we_EX && (rd_data_sel_EX == 2'b01) && !invalid_EX;
  assign w_load_mp  = regfile_we_MEMPREP && (rd_data_sel_MEMPREP == 2'b01);
  assign w_hz_ex    = w_load_ex && (w_rs1_hit_ex || w_rs2_hit_ex);
  assign w_hz_mp    = c_mp_en && w_load_mp && (w_rs1_hit_mp || w_rs2_hit_mp);
  assign w_lsu_wait = lsu_req_MEM && !lsu_ack;
  assign w_branch   = branch_taken_EX && !invalid_EX;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= c_st_run;
      r_bub_cnt     <= 2'd0;
      r_wait_cnt    <= 8'd0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_bub_cnt     <= w_bub_nxt;
      r_wait_cnt    <= w_wait_nxt;
      r_mem_timeout <= w_tmo_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bub_nxt   = r_bub_cnt;
    w_wait_nxt  = r_wait_cnt;
    w_tmo_nxt   = r_mem_timeout;
    case (r_state)
      c_st_run: begin
        if (w_lsu_wait) begin
          w_state_nxt = c_st_mem_wait;
          w_wait_nxt  = 8'd1;
        end else if (w_branch) begin
          w_state_nxt = c_st_run;
        end else if (w_hz_ex) begin
          w_bub_nxt   = c_bub_ex;
          w_state_nxt = (c_bub_ex != 2'd0) ? c_st_load_use : c_st_run;
        end else if (w_hz_mp) begin
          w_bub_nxt   = c_bub_mp;
          w_state_nxt = (c_bub_mp != 2'd0) ? c_st_load_use : c_st_run;
        end
      end
      c_st_load_use: begin
        // A memory wait freezes the bubble sequence; the count resumes after release.
        if (w_lsu_wait) begin
          w_state_nxt = c_st_mem_wait;
          w_wait_nxt  = 8'd1;
        end else begin
          w_bub_nxt   = (r_bub_cnt != 2'd0) ? r_bub_cnt - 2'd1 : 2'd0;
          w_state_nxt = (r_bub_cnt <= 2'd1) ? c_st_run : c_st_load_use;
        end
      end
      c_st_mem_wait: begin
        if (lsu_ack) begin
          w_wait_nxt  = 8'd0;
          w_state_nxt = (r_bub_cnt != 2'd0) ? c_st_load_use : c_st_run;
        end else if (r_wait_cnt == c_timeout) begin
          w_tmo_nxt   = 1'b1;
          w_wait_nxt  = 8'd0;
          w_bub_nxt   = 2'd0;
          w_state_nxt = c_st_run;
        end else begin
          w_wait_nxt  = r_wait_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = c_st_run;
        w_bub_nxt   = 2'd0;
        w_wait_nxt  = 8'd0;
      end
    endcase
  end

  always_comb begin
    stall_IF   = 1'b0;
    stall_ID   = 1'b0;
    bubble_EX  = 1'b0;
    flush_IF   = 1'b0;
    flush_ID   = 1'b0;
    stall_MEM  = 1'b0;
    ctrl_state = 2'd0;
    if (rst_n) begin
      ctrl_state = r_state;
      case (r_state)
        c_st_run: begin
          if (w_lsu_wait) begin
            stall_IF  = 1'b1;
            stall_ID  = 1'b1;
            stall_MEM = 1'b1;
          end else if (w_branch) begin
            flush_IF  = 1'b1;
            flush_ID  = 1'b1;
          end else if (w_hz_ex || w_hz_mp) begin
            stall_IF  = 1'b1;
            stall_ID  = 1'b1;
            bubble_EX = 1'b1;
          end
        end
        c_st_load_use: begin
          stall_IF = 1'b1;
          stall_ID = 1'b1;
          if (w_lsu_wait) stall_MEM = 1'b1;
          else            bubble_EX = 1'b1;
        end
        c_st_mem_wait: begin
          // Ack releases the whole pipeline in the same cycle it arrives.
          if (!lsu_ack) begin
            stall_IF  = 1'b1;
            stall_ID  = 1'b1;
            stall_MEM = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_timeout = r_mem_timeout;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_perf_stall, r_perf_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall <= 32'd0;
      r_perf_flush <= 32'd0;
    end else begin
      if (stall_IF && (r_perf_stall != 32'hFFFF_FFFF)) r_perf_stall <= r_perf_stall + 32'd1;
      if (flush_IF && (r_perf_flush != 32'hFFFF_FFFF)) r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_flush_count  = r_perf_flush;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipeline_hazard_controller: directed bench for the hazard sequencer    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] rs1_ID, rs2_ID, rd_EX, rd_MEMPREP;
  logic       rs1_used_ID, rs2_used_ID, regfile_we_EX, invalid_EX, regfile_we_MEMPREP;
  logic [1:0] rd_data_sel_EX, rd_data_sel_MEMPREP;
  logic       branch_taken_EX, lsu_req_MEM, lsu_ack;
  logic       stall_IF, stall_ID, bubble_EX, flush_IF, flush_ID, stall_MEM, mem_timeout;
  logic [1:0] ctrl_state;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cycles, perf_flush_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  pipeline_hazard_controller #(.LOAD_USE_BUBBLES(2), .MEM_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
    .rd_EX(rd_EX), .regfile_we_EX(regfile_we_EX), .rd_data_sel_EX(rd_data_sel_EX),
    .invalid_EX(invalid_EX), .rd_MEMPREP(rd_MEMPREP), .regfile_we_MEMPREP(regfile_we_MEMPREP),
    .rd_data_sel_MEMPREP(rd_data_sel_MEMPREP), .branch_taken_EX(branch_taken_EX),
    .lsu_req_MEM(lsu_req_MEM), .lsu_ack(lsu_ack),
    .stall_IF(stall_IF), .stall_ID(stall_ID), .bubble_EX(bubble_EX), .flush_IF(flush_IF),
    .flush_ID(flush_ID), .stall_MEM(stall_MEM), .ctrl_state(ctrl_state), .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_flush_count(perf_flush_count)
`endif
  );

  always #5 clk = ~clk;

  // Vector order: stall_IF stall_ID bubble_EX flush_IF flush_ID stall_MEM ctrl_state[1:0] mem_timeout
  task automatic chk(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = {stall_IF, stall_ID, bubble_EX, flush_IF, flush_ID, stall_MEM, ctrl_state, mem_timeout};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rs1_ID = 4'd0; rs2_ID = 4'd0; rs1_used_ID = 1'b0; rs2_used_ID = 1'b0;
    rd_EX = 4'd0; regfile_we_EX = 1'b0; rd_data_sel_EX = 2'b00; invalid_EX = 1'b0;
    rd_MEMPREP = 4'd0; regfile_we_MEMPREP = 1'b0; rd_data_sel_MEMPREP = 2'b00;
    branch_taken_EX = 1'b0; lsu_req_MEM = 1'b0; lsu_ack = 1'b0;
  endtask

  task automatic load_ex_use_rs1(input logic [3:0] r);
    rd_EX = r; regfile_we_EX = 1'b1; rd_data_sel_EX = 2'b01; invalid_EX = 1'b0;
    rs1_ID = r; rs1_used_ID = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    // Reset held with a live hazard: outputs must be forced low
    step(); load_ex_use_rs1(4'd5); #1 chk("reset_forced", 9'b000000_00_0);
    step(); rst_n = 1'b1; idle(); #1 chk("after_release", 9'b000000_00_0);

    // Load-use with producer in EX: two bubble cycles, one in LOAD_USE
    step(); load_ex_use_rs1(4'd5); #1 chk("luse_ex_c0", 9'b111000_00_0);
    step(); #1 chk("luse_ex_c1", 9'b111000_01_0);
    step(); invalid_EX = 1'b1; #1 chk("luse_ex_done", 9'b000000_00_0);

    // x0 never hazards; ALU result does not stall
    step(); idle(); load_ex_use_rs1(4'd0); #1 chk("x0_no_stall", 9'b000000_00_0);
    step(); load_ex_use_rs1(4'd5); rd_data_sel_EX = 2'b00; #1 chk("alu_no_stall", 9'b000000_00_0);
    step(); idle(); rd_EX = 4'd9; regfile_we_EX = 1'b1; rd_data_sel_EX = 2'b01;
    rs1_ID = 4'd9; rs1_used_ID = 1'b0; #1 chk("rs1_unused", 9'b000000_00_0);

    // rs2 load-use through MEMPREP: one bubble, stays in RUN
    step(); idle(); rd_MEMPREP = 4'd7; regfile_we_MEMPREP = 1'b1; rd_data_sel_MEMPREP = 2'b01;
    rs2_ID = 4'd7; rs2_used_ID = 1'b1; #1 chk("luse_mp", 9'b111000_00_0);
    step(); idle(); #1 chk("luse_mp_done", 9'b000000_00_0);

    // Branch beats load-use
    step(); load_ex_use_rs1(4'd5); branch_taken_EX = 1'b1; #1 chk("branch_over_luse", 9'b000110_00_0);
    step(); idle(); #1 chk("branch_one_cycle", 9'b000000_00_0);

    // Memory wait, ack on the 5th cycle
    step(); lsu_req_MEM = 1'b1; #1 chk("mw_enter", 9'b110001_00_0);
    for (int i = 0; i < 3; i++) begin
      step(); #1 chk("mw_wait", 9'b110001_10_0);
    end
    step(); lsu_ack = 1'b1; #1 chk("mw_ack", 9'b000000_10_0);
    step(); #1 chk("req_ack_same_cycle", 9'b000000_00_0);
    step(); idle(); #1 chk("mw_done", 9'b000000_00_0);

    // Timeout after 8 wait cycles, sticky flag
    step(); lsu_req_MEM = 1'b1; #1 chk("to_enter", 9'b110001_00_0);
    for (int i = 1; i <= 8; i++) begin
      step(); #1 chk("to_wait", 9'b110001_10_0);
    end
    step(); idle(); #1 chk("to_flag", 9'b000000_00_1);
    step(); #1 chk("to_sticky", 9'b000000_00_1);

    // Memory wait interrupting LOAD_USE resumes the remaining bubble
    step(); load_ex_use_rs1(4'd3); #1 chk("lu_mw_c0", 9'b111000_00_1);
    step(); lsu_req_MEM = 1'b1; #1 chk("lu_mw_enter", 9'b110001_01_1);
    step(); lsu_ack = 1'b1; #1 chk("lu_mw_ack", 9'b000000_10_1);
    step(); lsu_req_MEM = 1'b0; lsu_ack = 1'b0; #1 chk("lu_resume", 9'b111000_01_1);
    step(); invalid_EX = 1'b1; #1 chk("lu_resume_done", 9'b000000_00_1);

    // Branch held in frozen EX is acted on after release
    step(); idle(); lsu_req_MEM = 1'b1; branch_taken_EX = 1'b1; #1 chk("br_mw_enter", 9'b110001_00_1);
    step(); #1 chk("br_mw_wait", 9'b110001_10_1);
    step(); lsu_ack = 1'b1; #1 chk("br_mw_ack", 9'b000000_10_1);
    step(); lsu_req_MEM = 1'b0; lsu_ack = 1'b0; #1 chk("br_after", 9'b000110_00_1);

    // Reset in the middle of LOAD_USE
    step(); idle(); load_ex_use_rs1(4'd6); #1 chk("rst_lu_c0", 9'b111000_00_1);
    step(); #1 chk("rst_lu_c1", 9'b111000_01_1);
    rst_n = 1'b0; #1 chk("rst_mid_lu", 9'b000000_00_0);
    step(); rst_n = 1'b1; idle(); #1 chk("rst_resume", 9'b000000_00_0);
    step(); load_ex_use_rs1(4'd6); #1 chk("rst_clean_luse", 9'b111000_00_0);
    step(); #1 chk("rst_clean_lu", 9'b111000_01_0);
    step(); idle(); #1 chk("rst_clean_run", 9'b000000_00_0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
